// File: rtl/dot_product_accumulator_if.sv
// Handshake and data bundle between the multiply stage, the dot-product
// accumulator and the next layer stage.
// master: drives commands and products and consumes the result.
// slave: the accumulator side.
interface dot_product_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic              prod_valid;
    logic [PROD_W-1:0] prod_data;
    logic              prod_skipped;
    logic              out_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic [LEN_W-1:0]  out_skip_count;
    logic              out_overflow;
    logic              busy;

    modport master (
        output start, cfg_len, prod_valid, prod_data, prod_skipped, out_ready,
        input  out_valid, out_data, out_skip_count, out_overflow, busy
    );

    modport slave (
        input  start, cfg_len, prod_valid, prod_data, prod_skipped, out_ready,
        output out_valid, out_data, out_skip_count, out_overflow, busy
    );
endinterface

// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator: sums cfg_len signed products from the multiply
// stage, counts zero-skipped elements and holds the result behind a
// valid/ready output.
// Build option: define ACC_SATURATE_EN to clamp the accumulator on signed
// overflow instead of wrapping. out_overflow behaves the same either way.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start with a non-zero cfg_len
// S_ACCUM | accepting products until the programmed count is consumed
// S_HOLD  | result presented on out_*; waits for out_ready
module dot_product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    dot_product_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]         rem_q, rem_d;
    logic [LEN_W-1:0]         skip_q, skip_d;
    logic                     ovf_q, ovf_d;

    logic signed [ACC_W-1:0]  addend;
    logic signed [ACC_W-1:0]  sum;
    logic                     add_ovf;

    // Candidate sum for the current product; skipped elements contribute zero.
    always_comb begin
        addend  = bus.prod_skipped ? '0 : ACC_W'($signed(bus.prod_data));
        sum     = acc_q + addend;
        add_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                  (sum[ACC_W-1] != acc_q[ACC_W-1]);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        skip_d  = skip_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.cfg_len != '0)) begin
                    state_d = S_ACCUM;
                    rem_d   = bus.cfg_len;
                    acc_d   = '0;
                    skip_d  = '0;
                    ovf_d   = 1'b0;
                end
            end

            S_ACCUM: begin
                if (bus.prod_valid) begin
                    if (bus.prod_skipped && (skip_q != '1)) begin
                        skip_d = skip_q + LEN_W'(1);
                    end
                    if (add_ovf) begin
                        ovf_d = 1'b1;
`ifdef ACC_SATURATE_EN
                        acc_d = addend[ACC_W-1] ? ACC_MIN : ACC_MAX;
`else
                        acc_d = sum;
`endif
                    end else begin
                        acc_d = sum;
                    end
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            skip_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            skip_q  <= skip_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_valid      = (state_q == S_HOLD);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.out_data       = acc_q;
    assign bus.out_skip_count = skip_q;
    assign bus.out_overflow   = ovf_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: a 32-bit accumulator instance for the
// main runs and a 16-bit one for the overflow case. Expected results are
// queued as each run is driven and compared when out_valid appears.
module tb_dot_product_accumulator;

    localparam int PW   = 16;
    localparam int LW   = 8;
    localparam int AW   = 32;
    localparam int AW_B = 16;

    logic clk_sys = 1'b0;
    logic rst;

    always #5 clk_sys = ~clk_sys;

    dot_product_accumulator_if #(.PROD_W(PW), .ACC_W(AW),   .LEN_W(LW)) bus_a ();
    dot_product_accumulator_if #(.PROD_W(PW), .ACC_W(AW_B), .LEN_W(LW)) bus_b ();

    dot_product_accumulator #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) u_dut (
        .clk (clk_sys),
        .rst (rst),
        .bus (bus_a)
    );

    dot_product_accumulator #(.PROD_W(PW), .ACC_W(AW_B), .LEN_W(LW)) u_dut16 (
        .clk (clk_sys),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        longint data;
        int     skip;
        bit     ovf;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    int   pd[8];
    bit   sk[8];
    int   gp[8];

    localparam logic [63:0] MASK_A = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] MASK_B = 64'h0000_0000_0000_FFFF;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference add on plain integers: out-of-range sums flag overflow and
    // are either clamped or folded back into the accw-bit range.
    task automatic model_add(input int accw, inout longint acc, inout bit ovf, input longint p);
        longint mx, mn, s;
        mx = (longint'(1) <<< (accw - 1)) - 1;
        mn = -(longint'(1) <<< (accw - 1));
        s  = acc + p;
        if (s > mx || s < mn) begin
            ovf = 1'b1;
`ifdef ACC_SATURATE_EN
            acc = (s > mx) ? mx : mn;
`else
            acc = (s > mx) ? s - (longint'(1) <<< accw) : s + (longint'(1) <<< accw);
`endif
        end else begin
            acc = s;
        end
    endtask

    task automatic idle_inputs();
        bus_a.start = 1'b0; bus_a.cfg_len = '0; bus_a.prod_valid = 1'b0;
        bus_a.prod_data = '0; bus_a.prod_skipped = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.start = 1'b0; bus_b.cfg_len = '0; bus_b.prod_valid = 1'b0;
        bus_b.prod_data = '0; bus_b.prod_skipped = 1'b0; bus_b.out_ready = 1'b0;
    endtask

    // Drives one dot product on bus_a from pd/sk/gp and queues its expectation.
    task automatic run_a(input int len, input bit start_in_gap);
        longint acc = 0;
        bit     ovf = 1'b0;
        int     skc = 0;
        exp_t   e;
        @(negedge clk_sys);
        bus_a.start   = 1'b1;
        bus_a.cfg_len = LW'(len);
        @(negedge clk_sys);
        bus_a.start = 1'b0;
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gp[i]; g++) begin
                bus_a.prod_valid = 1'b0;
                bus_a.start      = start_in_gap;
                bus_a.cfg_len    = LW'(7);
                @(negedge clk_sys);
            end
            bus_a.start        = 1'b0;
            bus_a.prod_valid   = 1'b1;
            bus_a.prod_data    = PW'(pd[i]);
            bus_a.prod_skipped = sk[i];
            if (sk[i]) begin
                if (skc < 255) skc++;
            end else begin
                model_add(AW, acc, ovf, longint'(pd[i]));
            end
            @(negedge clk_sys);
        end
        bus_a.prod_valid   = 1'b0;
        bus_a.prod_data    = '0;
        bus_a.prod_skipped = 1'b0;
        e.data = acc;
        e.skip = skc;
        e.ovf  = ovf;
        sb_q.push_back(e);
        check_val("latency_valid", 64'(bus_a.out_valid), 64'd1);
    endtask

    // Waits for the result, compares it, optionally stalls / pokes, then acks.
    task automatic collect_a(input int hold_cyc, input bit poke_hold, input bit start_on_ack);
        int   n = 0;
        exp_t e;
        logic [63:0] exp_data;
        while (!bus_a.out_valid && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        if (!bus_a.out_valid) begin
            check_val("wait_valid_timeout", 64'(bus_a.out_valid), 64'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 64'(sb_q.size()), 64'd1);
            return;
        end
        e = sb_q.pop_front();
        exp_data = 64'(e.data) & MASK_A;
        check_val("out_data",  64'(bus_a.out_data), exp_data);
        check_val("out_skip",  64'(bus_a.out_skip_count), 64'(e.skip));
        check_val("out_ovf",   64'(bus_a.out_overflow), 64'(e.ovf));
        check_val("busy_hold", 64'(bus_a.busy), 64'd1);
        for (int c = 0; c < hold_cyc; c++) begin
            @(negedge clk_sys);
            check_val("stall_valid", 64'(bus_a.out_valid), 64'd1);
            check_val("stall_data",  64'(bus_a.out_data), exp_data);
        end
        if (poke_hold) begin
            bus_a.prod_valid = 1'b1;
            bus_a.prod_data  = PW'(100);
            @(negedge clk_sys);
            bus_a.prod_valid = 1'b0;
            bus_a.prod_data  = '0;
            check_val("poke_valid", 64'(bus_a.out_valid), 64'd1);
            check_val("poke_data",  64'(bus_a.out_data), exp_data);
        end
        bus_a.out_ready = 1'b1;
        bus_a.start     = start_on_ack;
        bus_a.cfg_len   = LW'(3);
        @(negedge clk_sys);
        bus_a.out_ready = 1'b0;
        bus_a.start     = 1'b0;
        check_val("ack_valid", 64'(bus_a.out_valid), 64'd0);
        check_val("ack_busy",  64'(bus_a.busy), 64'd0);
        check_val("idle_data", 64'(bus_a.out_data), exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint acc_b;
        bit     ovf_b;

        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 8; i++) begin pd[i] = 0; sk[i] = 1'b0; gp[i] = 0; end
        #12;
        check_val("rst_valid", 64'(bus_a.out_valid), 64'd0);
        check_val("rst_data",  64'(bus_a.out_data), 64'd0);
        check_val("rst_skip",  64'(bus_a.out_skip_count), 64'd0);
        check_val("rst_ovf",   64'(bus_a.out_overflow), 64'd0);
        check_val("rst_busy",  64'(bus_a.busy), 64'd0);
        check_val("rst_b_data", 64'(bus_b.out_data), 64'd0);
        @(negedge clk_sys);
        rst = 1'b0;

        // Basic run with one skipped element carrying non-zero data.
        pd = '{60, 60, 'h1234, 0, 0, 0, 0, 0};
        sk = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        gp = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_a(3, 1'b0);
        collect_a(0, 1'b0, 1'b0);

        // Backpressure for 5 cycles; start coincident with the ack is ignored.
        pd = '{5, 7, 0, 0, 0, 0, 0, 0};
        sk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_a(2, 1'b0);
        collect_a(5, 1'b0, 1'b1);

        // Sign extension, product strobe in HOLD, zero-length start.
        pd = '{-1, 5, 0, 0, 0, 0, 0, 0};
        run_a(2, 1'b0);
        collect_a(0, 1'b1, 1'b0);
        @(negedge clk_sys);
        bus_a.start   = 1'b1;
        bus_a.cfg_len = '0;
        @(negedge clk_sys);
        bus_a.start = 1'b0;
        check_val("len0_busy", 64'(bus_a.busy), 64'd0);

        // Overflow on the 16-bit accumulator.
        acc_b = 0;
        ovf_b = 1'b0;
        @(negedge clk_sys);
        bus_b.start   = 1'b1;
        bus_b.cfg_len = LW'(2);
        @(negedge clk_sys);
        bus_b.start      = 1'b0;
        bus_b.prod_valid = 1'b1;
        bus_b.prod_data  = PW'('h7000);
        model_add(AW_B, acc_b, ovf_b, longint'('h7000));
        @(negedge clk_sys);
        model_add(AW_B, acc_b, ovf_b, longint'('h7000));
        @(negedge clk_sys);
        bus_b.prod_valid = 1'b0;
        bus_b.prod_data  = '0;
        check_val("b_valid", 64'(bus_b.out_valid), 64'd1);
        check_val("b_data",  64'(bus_b.out_data), 64'(acc_b) & MASK_B);
        check_val("b_ovf",   64'(bus_b.out_overflow), 64'(ovf_b));
        bus_b.out_ready = 1'b1;
        @(negedge clk_sys);
        bus_b.out_ready = 1'b0;
        check_val("b_ack_valid", 64'(bus_b.out_valid), 64'd0);

        // Asynchronous reset in the middle of ACCUM.
        bus_a.start   = 1'b1;
        bus_a.cfg_len = LW'(4);
        @(negedge clk_sys);
        bus_a.start      = 1'b0;
        bus_a.prod_valid = 1'b1;
        bus_a.prod_data  = PW'(3);
        @(negedge clk_sys);
        bus_a.prod_skipped = 1'b1;
        bus_a.prod_data    = '0;
        @(negedge clk_sys);
        bus_a.prod_valid   = 1'b0;
        bus_a.prod_skipped = 1'b0;
        check_val("pre_rst_data", 64'(bus_a.out_data), 64'd3);
        check_val("pre_rst_skip", 64'(bus_a.out_skip_count), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy",  64'(bus_a.busy), 64'd0);
        check_val("mid_rst_valid", 64'(bus_a.out_valid), 64'd0);
        check_val("mid_rst_data",  64'(bus_a.out_data), 64'd0);
        check_val("mid_rst_skip",  64'(bus_a.out_skip_count), 64'd0);
        check_val("mid_rst_ovf",   64'(bus_a.out_overflow), 64'd0);
        @(negedge clk_sys);
        rst = 1'b0;
        pd = '{9, 0, 0, 0, 0, 0, 0, 0};
        sk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        gp = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_a(1, 1'b0);
        collect_a(0, 1'b0, 1'b0);

        // Gapped stream with start pulses while accumulating.
        pd = '{2, 3, 4, 0, 0, 0, 0, 0};
        gp = '{0, 3, 1, 0, 0, 0, 0, 0};
        run_a(3, 1'b1);
        collect_a(1, 1'b0, 1'b0);

        check_val("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Sits directly downstream of the dequant/multiply pipeline and consumes its per-element product stream: result low bits, valid strobe, zero-skip flag.
- Sums a programmed number of products into one dot-product result and counts zero-skipped elements.
- Presents the result through a registered valid/ready output so the next layer stage can apply backpressure.

Parameters:
- PROD_W, 16, width of incoming product; signed two's complement.
- ACC_W, 32, accumulator and result width; must be >= PROD_W.
- LEN_W, 8, width of the element-count configuration and skip counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begin a new dot product; honoured only in IDLE.
- cfg_len  input  LEN_W  number of products to accumulate; sampled on an accepted start.
- prod_valid  input  1  product strobe from the multiply stage.
- prod_data  input  PROD_W  signed product value.
- prod_skipped  input  1  product was zero-skipped; prod_data is ignored when set.
- out_ready  input  1  downstream can accept the result.
- out_valid  output  1  result available.
- out_data  output  ACC_W  accumulated dot product, signed.
- out_skip_count  output  LEN_W  number of skipped products in this dot product.
- out_overflow  output  1  sticky flag: signed overflow occurred during this dot product.
- busy  output  1  high in ACCUM or HOLD.

Behaviour:
- Reset (async, any state): state=IDLE; accumulator, remaining count, skip counter and overflow flag cleared.
  - Outputs after reset: out_valid=0, out_data=0, out_skip_count=0, out_overflow=0, busy=0.
- States:
  - IDLE:
    - start=1 with cfg_len!=0 -> ACCUM. Load remaining=cfg_len; clear accumulator, skip counter and overflow.
    - start=1 with cfg_len==0 is ignored; stay in IDLE.
  - ACCUM: each cycle with prod_valid=1 accepts one element.
    - prod_skipped=1: add 0, skip counter+1.
    - Otherwise: add prod_data sign-extended to ACC_W.
    - remaining decrements on each accepted element.
    - When the element accepted has remaining==1 -> HOLD.
    - start is ignored in ACCUM.
  - HOLD: out_valid=1.
    - out_data, out_skip_count and out_overflow are stable and equal the final accumulated values.
    - out_valid && out_ready -> IDLE; out_valid deasserts on the next edge.
- Latency: out_valid rises on the clock edge that accepts the last product, i.e. it is visible the cycle after the last prod_valid.
- prod_valid in IDLE or HOLD: element dropped; no state change.
- start in the same cycle as the HOLD handshake is ignored. A new start is honoured the next cycle, from IDLE.
- Gaps (prod_valid=0) in ACCUM are allowed without limit; no timeout.
- Overflow: detected when the operands have the same sign and the sum sign differs. Once set, it stays set until the next accepted start or reset.
- out_data is updated only via the registered accumulator; it holds its last value in IDLE until the next start clears it.
- Skip counter saturates at 2^LEN_W-1; it cannot exceed cfg_len in practice.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined:
  - An overflowing add clamps the accumulator to the signed max (0111..1) or min (1000..0), according to the operand sign.
  - Later adds continue from the clamped value.
- Undefined:
  - Two's-complement wrap-around.
  - out_overflow is still computed and set identically in both builds.

Test Plan:
- cfg_len=3, start. Products 60, 60, then skipped (data=0x1234) -> out_valid one cycle after the 3rd strobe, out_data=120, out_skip_count=1, out_overflow=0.
- Backpressure: complete cfg_len=2 (5, 7) with out_ready=0 for 5 cycles -> out_data=12 held stable, out_valid held.
  - Then out_ready=1 -> out_valid=0 next cycle, busy=0.
- Sign handling: cfg_len=2, prod_data=0xFFFF (-1) then 5 -> out_data=4. Extra prod_valid in HOLD has no effect; start with cfg_len=0 in IDLE leaves busy=0.
- Overflow, with ACC_W=16 and PROD_W=16: products 0x7000, 0x7000.
  - With ACC_SATURATE_EN: out_data=0x7FFF.
  - Without it: out_data=0xE000.
  - out_overflow=1 in both builds.
- Reset mid-ACCUM: cfg_len=4, accept 2 products, assert rst between edges -> all outputs 0 immediately.
  - After release, a new cfg_len=1 run with product 9 gives out_data=9, out_skip_count=0.
- Gapped stream: cfg_len=3, products 2, 3, 4 separated by 0/3/1 idle cycles -> out_data=9.
  - start pulses during ACCUM are ignored.
